// File: rtl/cmult_mac.sv
// Pipelined complex multiply-accumulate with optional conj(B) and saturating accumulator.
// A sample accepted on edge k appears with out_valid after edge k+6; one sample per cycle.
module cmult_mac #(
  parameter int AWIDTH   = 16,
  parameter int BWIDTH   = 18,
  parameter int ACCWIDTH = 48
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic signed [AWIDTH-1:0]   ar,
  input  logic signed [AWIDTH-1:0]   ai,
  input  logic signed [BWIDTH-1:0]   br,
  input  logic signed [BWIDTH-1:0]   bi,
  input  logic                       conj_b,
  input  logic                       acc_en,
  input  logic                       acc_start,
  output logic                       out_valid,
  output logic signed [ACCWIDTH-1:0] pr,
  output logic signed [ACCWIDTH-1:0] pi,
  output logic                       ovf
);

  localparam int PW = AWIDTH + BWIDTH + 1;
  localparam int NS = 6;
  localparam logic [ACCWIDTH-1:0] ACC_MAX = {1'b0, {(ACCWIDTH-1){1'b1}}};
  localparam logic [ACCWIDTH-1:0] ACC_MIN = {1'b1, {(ACCWIDTH-1){1'b0}}};

  // Control pipeline: valid runs to the output stage, mode bits to the accumulator stage.
  logic [NS:1]   valid_reg;
  logic [NS-1:1] acc_en_reg;
  logic [NS-1:1] acc_start_reg;
  logic          conj_reg;

  logic signed [AWIDTH-1:0] ar_reg, ai_reg;
  logic signed [BWIDTH-1:0] br_reg, bi_reg;
  logic signed [AWIDTH-1:0] a_re_reg, a_im_reg;
  logic signed [BWIDTH-1:0] b_re_reg;
  logic signed [BWIDTH:0]   b_im_reg;
  logic signed [BWIDTH:0]   bi_wide;
  logic signed [PW-1:0]     mul_rr_reg, mul_ii_reg, mul_ri_reg, mul_ir_reg;
  logic signed [PW-1:0]     p_reg, q_reg;

  logic [1:0][ACCWIDTH-1:0] ext_reg;
  logic [1:0][ACCWIDTH-1:0] acc_reg;
  logic [1:0][ACCWIDTH-1:0] lane_sum;
  logic [1:0]               lane_sat;
  logic                     ovf_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg     <= '0;
      acc_en_reg    <= '0;
      acc_start_reg <= '0;
      conj_reg      <= 1'b0;
    end else begin
      valid_reg     <= {valid_reg[NS-1:1], in_valid};
      acc_en_reg    <= {acc_en_reg[NS-2:1], acc_en};
      acc_start_reg <= {acc_start_reg[NS-2:1], acc_start};
      conj_reg      <= conj_b;
    end
  end

  // Widening before negation keeps -(most negative bi) exact.
  assign bi_wide = (BWIDTH+1)'(bi_reg);

  // Datapath stages carry no reset; only the valid bits qualify them.
  always_ff @(posedge clk) begin
    ar_reg     <= ar;
    ai_reg     <= ai;
    br_reg     <= br;
    bi_reg     <= bi;
    a_re_reg   <= ar_reg;
    a_im_reg   <= ai_reg;
    b_re_reg   <= br_reg;
    b_im_reg   <= conj_reg ? -bi_wide : bi_wide;
    mul_rr_reg <= PW'(a_re_reg) * PW'(b_re_reg);
    mul_ii_reg <= PW'(a_im_reg) * PW'(b_im_reg);
    mul_ri_reg <= PW'(a_re_reg) * PW'(b_im_reg);
    mul_ir_reg <= PW'(a_im_reg) * PW'(b_re_reg);
    p_reg      <= mul_rr_reg - mul_ii_reg;
    q_reg      <= mul_ri_reg + mul_ir_reg;
    ext_reg[0] <= ACCWIDTH'(p_reg);
    ext_reg[1] <= ACCWIDTH'(q_reg);
  end

  // Lane 0 is the real part, lane 1 the imaginary part; each saturates on its own.
  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    logic [ACCWIDTH:0] sum;
    assign sum = {acc_reg[gi][ACCWIDTH-1], acc_reg[gi]}
               + {ext_reg[gi][ACCWIDTH-1], ext_reg[gi]};
    assign lane_sat[gi] = sum[ACCWIDTH] ^ sum[ACCWIDTH-1];
    assign lane_sum[gi] = lane_sat[gi] ? (sum[ACCWIDTH] ? ACC_MIN : ACC_MAX)
                                       : sum[ACCWIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg <= '0;
      ovf_reg <= 1'b0;
    end else if (valid_reg[NS-1]) begin
      if (!acc_en_reg[NS-1]) begin
        acc_reg <= ext_reg;
      end else if (acc_start_reg[NS-1]) begin
        acc_reg <= ext_reg;
        ovf_reg <= 1'b0;
      end else begin
        acc_reg <= lane_sum;
        if (|lane_sat) begin
          ovf_reg <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      pr        <= '0;
      pi        <= '0;
      ovf       <= 1'b0;
    end else begin
      out_valid <= valid_reg[NS];
      if (valid_reg[NS]) begin
        pr  <= acc_reg[0];
        pi  <= acc_reg[1];
        ovf <= ovf_reg;
      end
    end
  end

endmodule

// File: tb/tb_cmult_mac.sv
// Scoreboard bench for cmult_mac: stimulus pushes hand-computed results, a monitor pops on out_valid.
module tb_cmult_mac;

  localparam int AW = 8;
  localparam int BW = 9;
  localparam int CW = 18;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic signed [AW-1:0] ar, ai;
  logic signed [BW-1:0] br, bi;
  logic                 conj_b, acc_en, acc_start;
  logic                 out_valid;
  logic signed [CW-1:0] pr, pi;
  logic                 ovf;

  always #5 clk = ~clk;

  cmult_mac #(.AWIDTH(AW), .BWIDTH(BW), .ACCWIDTH(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .ar(ar), .ai(ai), .br(br), .bi(bi),
    .conj_b(conj_b), .acc_en(acc_en), .acc_start(acc_start),
    .out_valid(out_valid), .pr(pr), .pi(pi), .ovf(ovf)
  );

  typedef struct {
    string name;
    int    cyc;
    longint pr;
    longint pi;
    longint ovf;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every out_valid must match the oldest expectation, including its cycle.
  always @(negedge clk) begin
    if (out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: out_valid at cyc %0d pr=%0d pi=%0d, none expected", cyc, pr, pi);
      end else begin
        mon_e = sb.pop_front();
        $display("txn %s cyc=%0d pr=%0d pi=%0d ovf=%0d", mon_e.name, cyc, pr, pi, ovf);
        chk({mon_e.name, " cyc"}, cyc, mon_e.cyc);
        chk({mon_e.name, " pr"}, pr, mon_e.pr);
        chk({mon_e.name, " pi"}, pi, mon_e.pi);
        chk({mon_e.name, " ovf"}, ovf, mon_e.ovf);
      end
    end
  end

  // Called at a negedge: drives one sample for the next rising edge, then advances a cycle.
  task automatic send(input string name, input int a_r, input int a_i, input int b_r, input int b_i,
                      input bit cj, input bit en, input bit st,
                      input bit expect_out, input int e_pr, input int e_pi, input bit e_ovf);
    exp_t e;
    in_valid  = 1'b1;
    ar        = a_r[AW-1:0];
    ai        = a_i[AW-1:0];
    br        = b_r[BW-1:0];
    bi        = b_i[BW-1:0];
    conj_b    = cj;
    acc_en    = en;
    acc_start = st;
    if (expect_out) begin
      e.name = name;
      e.cyc  = cyc + 7;
      e.pr   = e_pr;
      e.pi   = e_pi;
      e.ovf  = e_ovf;
      sb.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic bubble();
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain(input string name);
    in_valid = 1'b0;
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    chk({name, " pending"}, sb.size(), 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0;
    ar = '0; ai = '0; br = '0; bi = '0;
    conj_b = 1'b0; acc_en = 1'b0; acc_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset out_valid", out_valid, 0);
    chk("reset pr", pr, 0);
    chk("reset pi", pi, 0);
    chk("reset ovf", ovf, 0);
    rst = 1'b0;

    // Plain product, then conj(B), then alternating conj with no gap.
    send("mul",     3, 4, 5, 6, 0, 0, 0, 1, -9, 38, 0);
    send("conj",    3, 4, 5, 6, 1, 0, 0, 1, 39,  2, 0);
    send("alt0",    3, 4, 5, 6, 0, 0, 0, 1, -9, 38, 0);
    send("alt1",    3, 4, 5, 6, 1, 0, 0, 1, 39,  2, 0);
    send("alt2",    3, 4, 5, 6, 0, 0, 0, 1, -9, 38, 0);

    // Most-negative operands.
    send("neg",     -128, -128, -256, -256, 0, 0, 0, 1, 0, 65536, 0);
    send("negconj", -128, -128, -256, -256, 1, 0, 0, 1, 65536, 0, 0);

    // Accumulation with a bubble after the second sample.
    send("acc1", 1, 1, 1, 1, 0, 1, 1, 1, 0, 2, 0);
    send("acc2", 1, 1, 1, 1, 0, 1, 0, 1, 0, 4, 0);
    bubble();
    send("acc3", 1, 1, 1, 1, 0, 1, 0, 1, 0, 6, 0);
    send("acc4", 1, 1, 1, 1, 0, 1, 0, 1, 0, 8, 0);

    // Saturation, sticky ovf through a plain sample, cleared by acc_start, set again.
    send("sat1",  -128, -128, -256, -256, 1, 1, 1, 1, 65536,  0, 0);
    send("sat2",  -128, -128, -256, -256, 1, 1, 0, 1, 131071, 0, 1);
    send("stick", 3, 4, 5, 6, 0, 0, 0, 1, -9, 38, 1);
    send("clear", 3, 4, 5, 6, 0, 1, 1, 1, -9, 38, 0);
    send("sat3",  -128, -128, -256, -256, 1, 1, 1, 1, 65536,  0, 0);
    send("sat4",  -128, -128, -256, -256, 1, 1, 0, 1, 131071, 0, 1);
    drain("pre-reset");

    // Three samples in flight are discarded by a one-cycle reset; in_valid during reset is ignored.
    send("fly1", 3, 4, 5, 6, 0, 0, 0, 0, 0, 0, 0);
    send("fly2", 3, 4, 5, 6, 1, 0, 0, 0, 0, 0, 0);
    send("fly3", 1, 1, 1, 1, 0, 1, 1, 0, 0, 0, 0);
    rst = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    chk("midreset out_valid", out_valid, 0);
    chk("midreset pr", pr, 0);
    chk("midreset pi", pi, 0);
    chk("midreset ovf", ovf, 0);

    // First sample after reset: cleared accumulator adds from zero.
    send("post", 1, 1, 1, 1, 0, 1, 0, 1, 0, 2, 0);
    drain("final");
    repeat (10) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
